// File: rtl/run_sched_pkg.sv
// Shared types and constants for the run-detect scheduler and its serial detector.
package run_sched_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_st_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_RUN_LEN = 4;

  // Detector holds a start state plus RUN_LEN lengths for each polarity.
  function automatic int det_sw(input int run_len);
    return $clog2(2 * run_len + 1);
  endfunction
endpackage

// File: rtl/run_detect_sched_if.sv
// Requester handshake and result bus of the run-detect scheduler.
interface run_detect_sched_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) ();
  logic [1:0]       req;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [CW-1:0]    hit_cnt;
  logic             any_hit;

  modport master (output req, data0, data1,
                  input  gnt, busy, done, done_id, hit_cnt, any_hit);
  modport slave  (input  req, data0, data1,
                  output gnt, busy, done, done_id, hit_cnt, any_hit);
endinterface

// File: rtl/run_detector.sv
// Moore run detector: out=1 once the last RUN_LEN bits seen were identical.
module run_detector
  import run_sched_pkg::*;
#(
  parameter int RUN_LEN = DEF_RUN_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic in,
  output logic out
);
  localparam int SW = det_sw(RUN_LEN);
  // 0 = start, 1..RUN_LEN = run of zeros, RUN_LEN+1..2*RUN_LEN = run of ones
  localparam logic [SW-1:0] Z1 = SW'(1);
  localparam logic [SW-1:0] ZN = SW'(RUN_LEN);
  localparam logic [SW-1:0] O1 = SW'(RUN_LEN + 1);
  localparam logic [SW-1:0] ON = SW'(2 * RUN_LEN);

  logic [SW-1:0] st_q, st_d;

  always_comb begin
    st_d = st_q;
    if (clr)
      st_d = '0;
    else if (in)
      st_d = (st_q >= O1) ? ((st_q == ON) ? ON : st_q + 1'b1) : O1;
    else
      st_d = (st_q >= O1 || st_q == '0) ? Z1 : ((st_q == ZN) ? ZN : st_q + 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!reset) st_q <= '0;
    else        st_q <= st_d;
  end

  assign out = (st_q == ZN) || (st_q == ON);
endmodule

// File: rtl/run_detect_sched.sv
// Round-robin scheduler sharing one serial run detector between two requesters;
// reports per-word hit count with the served requester id.
module run_detect_sched
  import run_sched_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int RUN_LEN = DEF_RUN_LEN,
  parameter int CW      = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  run_detect_sched_if.slave   bus
);
  localparam int KW = $clog2(WIDTH);

  sched_st_e        st_q, st_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [KW-1:0]    k_q, k_d;
  logic             sel_q, sel_d;
  logic             rr_last_q, rr_last_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             any_q, any_d;
  logic [1:0]       gnt;
  logic             win;
  logic             det_clr;
  logic             det_out;
  logic [CW-1:0]    cnt_fin;

  // On a tie the requester not served last wins.
  assign win     = (bus.req == 2'b11) ? ~rr_last_q : bus.req[1];
  assign cnt_fin = acc_q + CW'(det_out);

  always_comb begin
    st_d      = st_q;
    word_d    = word_q;
    k_d       = k_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    any_d     = any_q;
    gnt       = '0;
    det_clr   = 1'b0;
    case (st_q)
      IDLE: if (|bus.req) begin
        gnt[win]  = 1'b1;
        word_d    = win ? bus.data1 : bus.data0;
        sel_d     = win;
        rr_last_d = win;
        k_d       = '0;
        acc_d     = '0;
        det_clr   = 1'b1;
        st_d      = SHIFT;
      end
      SHIFT: begin
        word_d = word_q >> 1;
        k_d    = k_q + 1'b1;
        // detector output lags one bit, so k=0 carries nothing from this word
        if (k_q != '0 && det_out) acc_d = acc_q + 1'b1;
        if (k_q == KW'(WIDTH - 1)) st_d = DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_fin;
        id_d  = sel_q;
        any_d = (cnt_fin != '0);
        st_d  = DONE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q      <= IDLE;
      word_q    <= '0;
      k_q       <= '0;
      sel_q     <= 1'b0;
      rr_last_q <= 1'b1;
      acc_q     <= '0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      any_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      word_q    <= word_d;
      k_q       <= k_d;
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      any_q     <= any_d;
    end
  end

  run_detector #(.RUN_LEN(RUN_LEN)) u_det (
    .clk   (clk),
    .reset (reset),
    .clr   (det_clr),
    .in    (word_q[0]),
    .out   (det_out)
  );

  assign bus.gnt     = reset ? gnt : 2'b00;
  assign bus.busy    = (st_q != IDLE);
  assign bus.done    = (st_q == DONE);
  assign bus.done_id = id_q;
  assign bus.hit_cnt = cnt_q;
  assign bus.any_hit = any_q;
endmodule
